timer_base_ctrl: RTL and testbench

Time-base controller and interrupt scheduler for the general-purpose timer. It generates the shared counter value, the run flag and the overflow pulse that drive every input-capture/output-compare channel. It supports a prescaler, auto-reload, and a repetition count for one-shot operation. It also merges the overflow event and the per-channel capture requests into one pending/enable interrupt request for the bus-side register file.

---
 rtl/timer_base_ctrl.sv | 127 ++++++++++++
 tb/tb_timer_base_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_base_ctrl.sv
// Shared time base (prescaler, auto-reload, repetition) for the timer channels,
// plus the pending/enable interrupt aggregation for overflow and capture events.
module timer_base_ctrl #(
    parameter int timer_width = 16,
    parameter int channel_n   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   timer_run_set,
    input  logic                   timer_run_clr,
    input  logic [timer_width-1:0] timer_psc,
    input  logic [timer_width-1:0] timer_arr,
    input  logic [7:0]             timer_rep,
    output logic [timer_width-1:0] timer_cnt_now_v,
    output logic                   timer_started,
    output logic                   timer_expired,
    input  logic [channel_n-1:0]   cap_itr_req,
    input  logic [channel_n:0]     itr_en,
    input  logic [channel_n:0]     itr_pnd_clr,
    output logic [channel_n:0]     itr_pnd,
    output logic                   itr_req
);

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [timer_width-1:0] ONE = {{(timer_width-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [timer_width-1:0] cnt_q, cnt_d;
    logic [timer_width-1:0] psc_cnt_q, psc_cnt_d;
    logic [timer_width-1:0] psc_sh_q, psc_sh_d;
    logic [timer_width-1:0] arr_sh_q, arr_sh_d;
    logic [7:0]             rep_sh_q, rep_sh_d;
    logic [7:0]             rep_cnt_q, rep_cnt_d;
    logic                   expired_q, expired_d;
    logic [channel_n:0]     pnd_q, pnd_d;
    logic                   tick;
    logic                   ovf;

    // A stop request freezes the counters in the same cycle, so no tick is taken.
    assign tick = (state_q == RUN) && !timer_run_clr && (psc_cnt_q == psc_sh_q);
    assign ovf  = tick && (cnt_q == arr_sh_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            psc_cnt_q <= '0;
            psc_sh_q  <= '0;
            arr_sh_q  <= '0;
            rep_sh_q  <= '0;
            rep_cnt_q <= '0;
            expired_q <= 1'b0;
            pnd_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            psc_cnt_q <= psc_cnt_d;
            psc_sh_q  <= psc_sh_d;
            arr_sh_q  <= arr_sh_d;
            rep_sh_q  <= rep_sh_d;
            rep_cnt_q <= rep_cnt_d;
            expired_q <= expired_d;
            pnd_q     <= pnd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        psc_cnt_d = psc_cnt_q;
        psc_sh_d  = psc_sh_q;
        arr_sh_d  = arr_sh_q;
        rep_sh_d  = rep_sh_q;
        rep_cnt_d = rep_cnt_q;
        expired_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (timer_run_set && !timer_run_clr) begin
                    state_d   = RUN;
                    psc_sh_d  = timer_psc;
                    arr_sh_d  = timer_arr;
                    rep_sh_d  = timer_rep;
                    psc_cnt_d = '0;
                    cnt_d     = '0;
                    rep_cnt_d = '0;
                end
            end
            RUN: begin
                if (timer_run_clr) begin
                    state_d = IDLE;
                end else if (tick) begin
                    psc_cnt_d = '0;
                    if (ovf) begin
                        cnt_d     = '0;
                        expired_d = 1'b1;
                        psc_sh_d  = timer_psc;
                        arr_sh_d  = timer_arr;
                        // Non-zero repetition: last overflow ends the run on the same edge.
                        if (rep_sh_q != 8'd0) begin
                            rep_cnt_d = rep_cnt_q + 8'd1;
                            if (rep_cnt_q + 8'd1 == rep_sh_q) begin
                                state_d = IDLE;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end else begin
                    psc_cnt_d = psc_cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Set has priority over a simultaneous write-1-to-clear.
        pnd_d = (pnd_q & ~itr_pnd_clr) | {cap_itr_req, ovf};
    end

    assign timer_cnt_now_v = cnt_q;
    assign timer_started   = (state_q == RUN);
    assign timer_expired   = expired_q;
    assign itr_pnd         = pnd_q;
    assign itr_req         = |(pnd_q & itr_en);

endmodule

// File: tb/tb_timer_base_ctrl.sv
// Scoreboard bench for timer_base_ctrl: expected per-cycle values are queued with
// the stimulus and compared once the DUT has produced the corresponding cycle.
module tb_timer_base_ctrl;

    localparam int TW = 16;
    localparam int CN = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          timer_run_set;
    logic          timer_run_clr;
    logic [TW-1:0] timer_psc;
    logic [TW-1:0] timer_arr;
    logic [7:0]    timer_rep;
    logic [TW-1:0] timer_cnt_now_v;
    logic          timer_started;
    logic          timer_expired;
    logic [CN-1:0] cap_itr_req;
    logic [CN:0]   itr_en;
    logic [CN:0]   itr_pnd_clr;
    logic [CN:0]   itr_pnd;
    logic          itr_req;

    timer_base_ctrl #(.timer_width(TW), .channel_n(CN)) dut (
        .clk            (clk),
        .reset          (reset),
        .timer_run_set  (timer_run_set),
        .timer_run_clr  (timer_run_clr),
        .timer_psc      (timer_psc),
        .timer_arr      (timer_arr),
        .timer_rep      (timer_rep),
        .timer_cnt_now_v(timer_cnt_now_v),
        .timer_started  (timer_started),
        .timer_expired  (timer_expired),
        .cap_itr_req    (cap_itr_req),
        .itr_en         (itr_en),
        .itr_pnd_clr    (itr_pnd_clr),
        .itr_pnd        (itr_pnd),
        .itr_req        (itr_req)
    );

    always #5 clk = ~clk;

    typedef enum int {S_CNT, S_STA, S_EXP, S_PND, S_REQ} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_of(input sig_e s);
        case (s)
            S_CNT:   return 32'(timer_cnt_now_v);
            S_STA:   return 32'(timer_started);
            S_EXP:   return 32'(timer_expired);
            S_PND:   return 32'(itr_pnd);
            S_REQ:   return 32'(itr_req);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input string tag, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk_eq(e.tag, obs_of(e.sig), e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic settle();
        #1;
        drain();
    endtask

    // Start pulse in cycle T; checks the T+1 state (running, cnt=0, no pulse).
    task automatic start_timer(input string name, input int psc, input int arr, input int rep);
        timer_psc     = TW'(psc);
        timer_arr     = TW'(arr);
        timer_rep     = 8'(rep);
        timer_run_set = 1'b1;
        push({name, "_start_sta"}, S_STA, 1);
        push({name, "_start_cnt"}, S_CNT, 0);
        push({name, "_start_exp"}, S_EXP, 0);
        step();
        timer_run_set = 1'b0;
    endtask

    task automatic stop_timer(input string name);
        timer_run_clr = 1'b1;
        push({name, "_stop_sta"}, S_STA, 0);
        step();
        timer_run_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sh_cnt[9];
        sh_cnt = '{0, 1, 2, 3, 0, 1, 0, 1, 0};

        reset         = 1'b1;
        timer_run_set = 1'b0;
        timer_run_clr = 1'b0;
        timer_psc     = '0;
        timer_arr     = '0;
        timer_rep     = '0;
        cap_itr_req   = '0;
        itr_en        = '1;
        itr_pnd_clr   = '0;
        step();
        push("rst_cnt", S_CNT, 0);
        push("rst_sta", S_STA, 0);
        push("rst_exp", S_EXP, 0);
        push("rst_pnd", S_PND, 0);
        push("rst_req", S_REQ, 0);
        step();
        reset = 1'b0;

        // Free-running: psc=0, arr=3; pulses at T+5, T+9, T+13
        start_timer("free", 0, 3, 0);
        for (int k = 2; k <= 14; k++) begin
            push($sformatf("free_cnt_k%0d", k), S_CNT, (k - 1) % 4);
            push($sformatf("free_exp_k%0d", k), S_EXP, ((k - 1) % 4 == 0));
            if (k == 5) push("free_pnd0", S_PND, 1);
            step();
        end
        push("free_hold_cnt", S_CNT, 1);
        stop_timer("free");
        itr_pnd_clr = '1;
        push("free_pnd_clr", S_PND, 0);
        step();
        itr_pnd_clr = '0;

        // Prescaled: psc=2, arr=1; each value held 3 clks, pulse every 6
        start_timer("psc", 2, 1, 0);
        for (int k = 2; k <= 14; k++) begin
            push($sformatf("psc_cnt_k%0d", k), S_CNT, ((k - 1) / 3) % 2);
            push($sformatf("psc_exp_k%0d", k), S_EXP, ((k - 1) % 6 == 0));
            step();
        end
        stop_timer("psc");

        // One-shot: psc=0, arr=2, rep=2, run twice
        for (int r = 0; r < 2; r++) begin
            start_timer($sformatf("rep%0d", r), 0, 2, 2);
            for (int k = 2; k <= 9; k++) begin
                push($sformatf("rep%0d_sta_k%0d", r, k), S_STA, (k <= 6));
                push($sformatf("rep%0d_cnt_k%0d", r, k), S_CNT, (k <= 6) ? (k - 1) % 3 : 0);
                push($sformatf("rep%0d_exp_k%0d", r, k), S_EXP, (k == 4 || k == 7));
                step();
            end
        end

        // Shadow update: arr 3 -> 1 while cnt=1
        start_timer("shadow", 0, 3, 0);
        push("shadow_cnt_k2", S_CNT, 1);
        step();
        timer_arr = TW'(1);
        for (int k = 3; k <= 9; k++) begin
            push($sformatf("shadow_cnt_k%0d", k), S_CNT, sh_cnt[k - 1]);
            push($sformatf("shadow_exp_k%0d", k), S_EXP, (k == 5 || k == 7 || k == 9));
            step();
        end
        stop_timer("shadow");

        // arr=0: cnt stays 0, pulse every psc+1 clks
        start_timer("arr0", 1, 0, 0);
        for (int k = 2; k <= 8; k++) begin
            push($sformatf("arr0_cnt_k%0d", k), S_CNT, 0);
            push($sformatf("arr0_exp_k%0d", k), S_EXP, (k >= 3 && (k % 2) == 1));
            step();
        end
        stop_timer("arr0");

        // psc=arr=0: pulse every clk while running
        start_timer("zero", 0, 0, 0);
        for (int k = 2; k <= 5; k++) begin
            push($sformatf("zero_cnt_k%0d", k), S_CNT, 0);
            push($sformatf("zero_exp_k%0d", k), S_EXP, 1);
            step();
        end
        stop_timer("zero");

        // Simultaneous set and clear stays idle
        timer_run_set = 1'b1;
        timer_run_clr = 1'b1;
        push("setclr_sta", S_STA, 0);
        step();
        timer_run_set = 1'b0;
        timer_run_clr = 1'b0;
        push("setclr_sta2", S_STA, 0);
        step();

        // Interrupt pending/enable collisions
        itr_en      = '0;
        itr_pnd_clr = '1;
        push("irq_clrall", S_PND, 0);
        step();
        itr_pnd_clr = '0;
        cap_itr_req = 4'b0010;
        push("irq_cap1_pnd", S_PND, 5'b00100);
        push("irq_cap1_req", S_REQ, 0);
        step();
        itr_pnd_clr = 5'b00100;
        push("irq_setclr_pnd", S_PND, 5'b00100);
        step();
        cap_itr_req = '0;
        itr_pnd_clr = '0;
        push("irq_en0_req", S_REQ, 0);
        settle();
        itr_en = 5'b00100;
        push("irq_en2_req", S_REQ, 1);
        settle();
        itr_pnd_clr = 5'b00100;
        push("irq_clr2_pnd", S_PND, 0);
        push("irq_clr2_req", S_REQ, 0);
        step();
        itr_pnd_clr = '0;
        cap_itr_req = 4'b1000;
        push("irq_cap3_pnd", S_PND, 5'b10000);
        push("irq_cap3_req", S_REQ, 0);
        step();
        cap_itr_req = '0;
        itr_pnd_clr = '1;
        push("irq_clrall2", S_PND, 0);
        step();
        itr_pnd_clr = '0;

        // Reset mid-run with pending bits set
        itr_en = '1;
        start_timer("mrst", 0, 3, 0);
        cap_itr_req = 4'b1111;
        push("mrst_cnt_k2", S_CNT, 1);
        push("mrst_pnd_k2", S_PND, 5'b11110);
        push("mrst_req_k2", S_REQ, 1);
        step();
        cap_itr_req = '0;
        push("mrst_cnt_k3", S_CNT, 2);
        step();
        reset = 1'b1;
        push("mrst_cnt", S_CNT, 0);
        push("mrst_sta", S_STA, 0);
        push("mrst_exp", S_EXP, 0);
        push("mrst_pnd", S_PND, 0);
        push("mrst_req", S_REQ, 0);
        step();
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
